mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Two-master arbiter and sequencer for the single shared CPU memory port.
- Master 0 is the instruction-fetch path; master 1 is the MEM stage (word address, strobe and rw signals from mem_ctrl).
- Grants the port to one master per transaction, fair round-robin on contention.
- Holds the address strobe until the memory signals ready, returns data with a one-cycle completion pulse, and aborts with an error on timeout.

Parameters:
- WORD_ADDR_WIDTH, 30, word address width.
- WORD_DATA_WIDTH, 32, data width.
- TIMEOUT_CYCLES, 16, max cycles in BUSY before abort (≥2).
- TMO_CNT_WIDTH, 5, timeout counter width (must hold TIMEOUT_CYCLES).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- m0_req_i, m1_req_i  in  1  transaction request; held until own rdy_o.
- m0_addr_i, m1_addr_i  in  WORD_ADDR_WIDTH  word address.
- m0_rw_i, m1_rw_i  in  1  1=read, 0=write.
- m0_wr_data_i, m1_wr_data_i  in  WORD_DATA_WIDTH  write data.
- m0_grant_o, m1_grant_o  out  1  master owns bus (BUSY or DONE).
- m0_rdy_o, m1_rdy_o  out  1  one-cycle completion pulse.
- m0_rd_data_o, m1_rd_data_o  out  WORD_DATA_WIDTH  read data, valid with rdy_o.
- m0_err_o, m1_err_o  out  1  timeout abort, valid with rdy_o.
- mem_addrs_o  out  1  address strobe to memory.
- mem_addr_o  out  WORD_ADDR_WIDTH  latched address.
- mem_rw_o  out  1  latched rw.
- mem_wr_data_o  out  WORD_DATA_WIDTH  latched write data.
- mem_rd_data_i  in  WORD_DATA_WIDTH  memory read data.
- mem_rdy_i  in  1  memory access complete.

Behaviour:
- All outputs registered. No combinational path from any input to any output.
- Reset (synchronous, any state, including mid-transaction):
  - state=IDLE, all outputs 0, timeout counter 0, last_owner=1 (so master 0 wins the first tie).
  - Any in-flight access is dropped, with no rdy_o or err_o.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - No request: stay in IDLE.
  - One request: that master becomes owner.
  - Both requesting: owner = !last_owner.
  - On grant (next edge): latch owner's addr/rw/wr_data into mem_*_o, set mem_addrs_o=1, owner grant_o=1, last_owner=owner, counter=0, go to BUSY.
  - Request-to-strobe latency is 1 cycle.
- BUSY:
  - mem_addrs_o and latched mem_* fields stay constant.
  - Master inputs are ignored; changes are not propagated.
  - mem_rdy_i=1: capture mem_rd_data_i into owner rd_data_o (captured for writes too, content don't-care), owner rdy_o=1, err_o=0, mem_addrs_o=0, go to DONE.
  - mem_rdy_i=0: counter++. If counter==TIMEOUT_CYCLES-1: owner rdy_o=1, err_o=1, rd_data_o=0, mem_addrs_o=0, go to DONE.
  - Same-cycle mem_rdy_i and timeout: mem_rdy_i wins; normal completion, no error.
- DONE (exactly 1 cycle):
  - Owner rdy_o high, grant_o high.
  - No new arbitration this cycle; the owner's still-asserted req is ignored.
  - Next edge: rdy_o, err_o and grant_o go to 0, go to IDLE.
- Timing with memory ready k cycles after strobe (k≥1): rdy_o at cycle k+1 after grant; next grant at the earliest at k+3.
- Non-owner rdy_o, err_o and rd_data_o are held at 0.
- At most one grant_o is high at any time.
- mem_rdy_i in IDLE or DONE is ignored.
- The arbiter does not check alignment. mem_ctrl handles misalignment by never raising m1_req_i.

Test Plan:
- Single read: m0_req_i=1, addr=0x0000_0010, rw=1; mem_rdy_i on the 2nd BUSY cycle with data 0xDEADBEEF → mem_addrs_o high 2 cycles, m0_rdy_o pulse 1 cycle with m0_rd_data_o=0xDEADBEEF, m0_err_o=0, back to IDLE.
- Contention fairness: both req held continuously, memory ready 1 cycle after strobe → grants alternate m0, m1, m0, m1; first grant is m0 after reset.
- Write: m1 rw=0, addr=0x3FFF_FFFF, data=0x1234_5678; m1_addr_i changed mid-BUSY → mem_addr_o stays 0x3FFF_FFFF, mem_wr_data_o=0x1234_5678, mem_rw_o=0, m1_rdy_o pulses.
- Timeout: m0 read, mem_rdy_i never asserted → after 16 BUSY cycles m0_rdy_o=1, m0_err_o=1, m0_rd_data_o=0, mem_addrs_o=0. With mem_rdy_i on exactly the 16th BUSY cycle → err_o=0.
- Reset mid-BUSY: assert reset for 1 cycle during BUSY → next cycle all outputs 0, no rdy_o pulse. A following tie grants m0.
- DONE blocking: m1 keeps req high through its DONE cycle while m0 is idle → no regrant in DONE; m1 is regranted from IDLE one cycle later.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter and sequencer for the shared memory port.
// Holds the strobe until ready, pulses completion, aborts on timeout.
module mem_bus_arbiter #(
    parameter int WORD_ADDR_WIDTH = 30,
    parameter int WORD_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES  = 16,
    parameter int TMO_CNT_WIDTH   = 5
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       m0_req_i,
    input  logic [WORD_ADDR_WIDTH-1:0] m0_addr_i,
    input  logic                       m0_rw_i,
    input  logic [WORD_DATA_WIDTH-1:0] m0_wr_data_i,
    input  logic                       m1_req_i,
    input  logic [WORD_ADDR_WIDTH-1:0] m1_addr_i,
    input  logic                       m1_rw_i,
    input  logic [WORD_DATA_WIDTH-1:0] m1_wr_data_i,
    output logic                       m0_grant_o,
    output logic                       m1_grant_o,
    output logic                       m0_rdy_o,
    output logic                       m1_rdy_o,
    output logic [WORD_DATA_WIDTH-1:0] m0_rd_data_o,
    output logic [WORD_DATA_WIDTH-1:0] m1_rd_data_o,
    output logic                       m0_err_o,
    output logic                       m1_err_o,
    output logic                       mem_addrs_o,
    output logic [WORD_ADDR_WIDTH-1:0] mem_addr_o,
    output logic                       mem_rw_o,
    output logic [WORD_DATA_WIDTH-1:0] mem_wr_data_o,
    input  logic [WORD_DATA_WIDTH-1:0] mem_rd_data_i,
    input  logic                       mem_rdy_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                     state_q;
    logic                       owner_q;
    logic                       last_q;
    logic [TMO_CNT_WIDTH-1:0]   cnt_q;
    logic [1:0]                 gnt_q;
    logic [1:0]                 rdy_q;
    logic [1:0]                 err_q;
    logic [WORD_DATA_WIDTH-1:0] rd0_q;
    logic [WORD_DATA_WIDTH-1:0] rd1_q;
    logic                       addrs_q;
    logic [WORD_ADDR_WIDTH-1:0] addr_q;
    logic                       rw_q;
    logic [WORD_DATA_WIDTH-1:0] wd_q;
    logic                       owner_d;
    logic                       timeout_d;

    // On a tie the master that did not win last time gets the bus.
    always_comb begin
        owner_d = m1_req_i;
        if (m0_req_i && m1_req_i) begin
            owner_d = ~last_q;
        end
    end

    assign timeout_d = (cnt_q == TMO_CNT_WIDTH'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= '0;
            gnt_q   <= '0;
            rdy_q   <= '0;
            err_q   <= '0;
            rd0_q   <= '0;
            rd1_q   <= '0;
            addrs_q <= 1'b0;
            addr_q  <= '0;
            rw_q    <= 1'b0;
            wd_q    <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (m0_req_i || m1_req_i) begin
                        state_q <= BUSY;
                        owner_q <= owner_d;
                        last_q  <= owner_d;
                        cnt_q   <= '0;
                        gnt_q   <= {owner_d, ~owner_d};
                        addrs_q <= 1'b1;
                        addr_q  <= owner_d ? m1_addr_i : m0_addr_i;
                        rw_q    <= owner_d ? m1_rw_i : m0_rw_i;
                        wd_q    <= owner_d ? m1_wr_data_i : m0_wr_data_i;
                    end
                end
                BUSY: begin
                    if (mem_rdy_i) begin
                        if (owner_q) rd1_q <= mem_rd_data_i;
                        else         rd0_q <= mem_rd_data_i;
                        rdy_q[owner_q] <= 1'b1;
                        err_q[owner_q] <= 1'b0;
                        addrs_q        <= 1'b0;
                        state_q        <= DONE;
                    end else if (timeout_d) begin
                        if (owner_q) rd1_q <= '0;
                        else         rd0_q <= '0;
                        rdy_q[owner_q] <= 1'b1;
                        err_q[owner_q] <= 1'b1;
                        addrs_q        <= 1'b0;
                        state_q        <= DONE;
                    end else begin
                        cnt_q <= cnt_q + TMO_CNT_WIDTH'(1);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    gnt_q   <= '0;
                    rdy_q   <= '0;
                    err_q   <= '0;
                    rd0_q   <= '0;
                    rd1_q   <= '0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign m0_grant_o    = gnt_q[0];
    assign m1_grant_o    = gnt_q[1];
    assign m0_rdy_o      = rdy_q[0];
    assign m1_rdy_o      = rdy_q[1];
    assign m0_err_o      = err_q[0];
    assign m1_err_o      = err_q[1];
    assign m0_rd_data_o  = rd0_q;
    assign m1_rd_data_o  = rd1_q;
    assign mem_addrs_o   = addrs_q;
    assign mem_addr_o    = addr_q;
    assign mem_rw_o      = rw_q;
    assign mem_wr_data_o = wd_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: transaction-level model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_mem_bus_arbiter;

    localparam int AW  = 30;
    localparam int DW  = 32;
    localparam int TMO = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          m0_req_i = 1'b0, m1_req_i = 1'b0;
    logic [AW-1:0] m0_addr_i = '0, m1_addr_i = '0;
    logic          m0_rw_i = 1'b0, m1_rw_i = 1'b0;
    logic [DW-1:0] m0_wr_data_i = '0, m1_wr_data_i = '0;
    logic          m0_grant_o, m1_grant_o, m0_rdy_o, m1_rdy_o;
    logic [DW-1:0] m0_rd_data_o, m1_rd_data_o;
    logic          m0_err_o, m1_err_o;
    logic          mem_addrs_o;
    logic [AW-1:0] mem_addr_o;
    logic          mem_rw_o;
    logic [DW-1:0] mem_wr_data_o;
    logic [DW-1:0] mem_rd_data_i = '0;
    logic          mem_rdy_i = 1'b0;

    int total = 0;
    int bad   = 0;

    mem_bus_arbiter #(
        .WORD_ADDR_WIDTH(AW),
        .WORD_DATA_WIDTH(DW),
        .TIMEOUT_CYCLES(TMO),
        .TMO_CNT_WIDTH(5)
    ) dut (
        .clk(clk),
        .reset(reset),
        .m0_req_i(m0_req_i),
        .m0_addr_i(m0_addr_i),
        .m0_rw_i(m0_rw_i),
        .m0_wr_data_i(m0_wr_data_i),
        .m1_req_i(m1_req_i),
        .m1_addr_i(m1_addr_i),
        .m1_rw_i(m1_rw_i),
        .m1_wr_data_i(m1_wr_data_i),
        .m0_grant_o(m0_grant_o),
        .m1_grant_o(m1_grant_o),
        .m0_rdy_o(m0_rdy_o),
        .m1_rdy_o(m1_rdy_o),
        .m0_rd_data_o(m0_rd_data_o),
        .m1_rd_data_o(m1_rd_data_o),
        .m0_err_o(m0_err_o),
        .m1_err_o(m1_err_o),
        .mem_addrs_o(mem_addrs_o),
        .mem_addr_o(mem_addr_o),
        .mem_rw_o(mem_rw_o),
        .mem_wr_data_o(mem_wr_data_o),
        .mem_rd_data_i(mem_rd_data_i),
        .mem_rdy_i(mem_rdy_i)
    );

    always #5 clk = ~clk;

    // Transaction model: who holds the bus, how many busy cycles have
    // elapsed, and whether the completion has been reported.
    bit            t_active = 1'b0;
    int            t_owner  = 0;
    int            t_last   = 1;
    int            t_busy   = 0;
    bit            t_done   = 1'b0;
    bit            t_err    = 1'b0;
    logic [DW-1:0] t_rd     = '0;
    logic [AW-1:0] t_addr   = '0;
    logic          t_rw     = 1'b0;
    logic [DW-1:0] t_wd     = '0;

    always @(posedge clk) begin
        if (reset) begin
            t_active = 1'b0;
            t_done   = 1'b0;
            t_err    = 1'b0;
            t_last   = 1;
            t_busy   = 0;
            t_rd     = '0;
            t_addr   = '0;
            t_rw     = 1'b0;
            t_wd     = '0;
        end else if (!t_active) begin
            if (m0_req_i || m1_req_i) begin
                if (m0_req_i && m1_req_i) t_owner = 1 - t_last;
                else                      t_owner = m1_req_i ? 1 : 0;
                t_last   = t_owner;
                t_active = 1'b1;
                t_done   = 1'b0;
                t_busy   = 0;
                t_addr   = t_owner == 1 ? m1_addr_i : m0_addr_i;
                t_rw     = t_owner == 1 ? m1_rw_i : m0_rw_i;
                t_wd     = t_owner == 1 ? m1_wr_data_i : m0_wr_data_i;
            end
        end else if (!t_done) begin
            t_busy = t_busy + 1;
            if (mem_rdy_i) begin
                t_done = 1'b1;
                t_err  = 1'b0;
                t_rd   = mem_rd_data_i;
            end else if (t_busy == TMO) begin
                t_done = 1'b1;
                t_err  = 1'b1;
                t_rd   = '0;
            end
        end else begin
            t_active = 1'b0;
            t_done   = 1'b0;
            t_err    = 1'b0;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
                     $time);
        end
    endtask

    function automatic logic own(input int m);
        return t_active && t_owner == m;
    endfunction

    always begin
        @(posedge clk);
        #2;
        chk("cmp.m0_grant", m0_grant_o, own(0));
        chk("cmp.m1_grant", m1_grant_o, own(1));
        chk("cmp.m0_rdy", m0_rdy_o, own(0) && t_done);
        chk("cmp.m1_rdy", m1_rdy_o, own(1) && t_done);
        chk("cmp.m0_err", m0_err_o, own(0) && t_done && t_err);
        chk("cmp.m1_err", m1_err_o, own(1) && t_done && t_err);
        chk("cmp.m0_rd", m0_rd_data_o, (own(0) && t_done) ? t_rd : '0);
        chk("cmp.m1_rd", m1_rd_data_o, (own(1) && t_done) ? t_rd : '0);
        chk("cmp.addrs", mem_addrs_o, t_active && !t_done);
        chk("cmp.addr", mem_addr_o, t_addr);
        chk("cmp.rw", mem_rw_o, t_rw);
        chk("cmp.wd", mem_wr_data_o, t_wd);
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        cyc(2);
        reset = 1'b0;
        chk("rst.grant", {m0_grant_o, m1_grant_o}, 2'b00);
        chk("rst.rdy", {m0_rdy_o, m1_rdy_o, m0_err_o, m1_err_o}, 4'h0);
        chk("rst.mem", {mem_addrs_o, mem_rw_o, mem_addr_o}, 32'h0);

        // single read, memory ready on the second busy cycle
        m0_req_i = 1'b1; m0_addr_i = 30'h10; m0_rw_i = 1'b1;
        cyc(1);
        chk("rd.grant", {m0_grant_o, m1_grant_o}, 2'b10);
        chk("rd.strobe1", mem_addrs_o, 1'b1);
        chk("rd.addr", mem_addr_o, 30'h10);
        cyc(1);
        chk("rd.strobe2", mem_addrs_o, 1'b1);
        mem_rdy_i = 1'b1; mem_rd_data_i = 32'hDEADBEEF;
        cyc(1);
        chk("rd.rdy", m0_rdy_o, 1'b1);
        chk("rd.data", m0_rd_data_o, 32'hDEADBEEF);
        chk("rd.err", m0_err_o, 1'b0);
        chk("rd.strobe_off", mem_addrs_o, 1'b0);
        mem_rdy_i = 1'b0; m0_req_i = 1'b0;
        cyc(1);
        chk("rd.idle", {m0_grant_o, m0_rdy_o}, 2'b00);

        // contention: fresh reset, both requesting, grants alternate
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        m0_req_i = 1'b1; m0_addr_i = 30'h100; m0_rw_i = 1'b1;
        m1_req_i = 1'b1; m1_addr_i = 30'h200; m1_rw_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc(1);
            chk("rr.grant", {m1_grant_o, m0_grant_o},
                (i % 2 == 0) ? 2'b01 : 2'b10);
            mem_rdy_i = 1'b1; mem_rd_data_i = 32'hA000_0000 + 32'(i);
            cyc(1);
            chk("rr.rdy", {m1_rdy_o, m0_rdy_o},
                (i % 2 == 0) ? 2'b01 : 2'b10);
            mem_rdy_i = 1'b0;
            cyc(1);
        end
        m0_req_i = 1'b0; m1_req_i = 1'b0;
        cyc(1);

        // write from m1, inputs change while busy
        m1_req_i = 1'b1; m1_rw_i = 1'b0;
        m1_addr_i = 30'h3FFF_FFFF; m1_wr_data_i = 32'h1234_5678;
        cyc(1);
        chk("wr.grant", m1_grant_o, 1'b1);
        m1_addr_i = 30'h5; m1_wr_data_i = 32'h0; m1_rw_i = 1'b1;
        cyc(1);
        chk("wr.addr", mem_addr_o, 30'h3FFF_FFFF);
        chk("wr.data", mem_wr_data_o, 32'h1234_5678);
        chk("wr.rw", mem_rw_o, 1'b0);
        mem_rdy_i = 1'b1;
        cyc(1);
        chk("wr.rdy", {m1_rdy_o, m1_err_o}, 2'b10);
        mem_rdy_i = 1'b0; m1_req_i = 1'b0;
        cyc(1);

        // memory ready while idle has no effect
        mem_rdy_i = 1'b1;
        cyc(2);
        chk("idle.rdy", {m0_rdy_o, m1_rdy_o, mem_addrs_o}, 3'b000);
        mem_rdy_i = 1'b0;

        // timeout: no ready for sixteen busy cycles
        m0_req_i = 1'b1; m0_addr_i = 30'h20; m0_rw_i = 1'b1;
        mem_rd_data_i = 32'hFFFF_0000;
        cyc(1);
        cyc(15);
        chk("tmo.strobe16", mem_addrs_o, 1'b1);
        chk("tmo.no_rdy", m0_rdy_o, 1'b0);
        cyc(1);
        chk("tmo.rdy", m0_rdy_o, 1'b1);
        chk("tmo.err", m0_err_o, 1'b1);
        chk("tmo.data", m0_rd_data_o, 32'h0);
        chk("tmo.strobe_off", mem_addrs_o, 1'b0);
        m0_req_i = 1'b0;
        cyc(1);

        // ready on exactly the sixteenth busy cycle wins over timeout
        m0_req_i = 1'b1;
        cyc(16);
        mem_rdy_i = 1'b1; mem_rd_data_i = 32'hCAFE_F00D;
        cyc(1);
        chk("tmo16.rdy", m0_rdy_o, 1'b1);
        chk("tmo16.err", m0_err_o, 1'b0);
        chk("tmo16.data", m0_rd_data_o, 32'hCAFE_F00D);
        mem_rdy_i = 1'b0; m0_req_i = 1'b0;
        cyc(1);

        // reset in the middle of an m0 access
        m0_req_i = 1'b1;
        cyc(2);
        reset = 1'b1; mem_rdy_i = 1'b1;
        cyc(1);
        chk("rstb.grant", {m0_grant_o, m1_grant_o}, 2'b00);
        chk("rstb.rdy", {m0_rdy_o, m0_err_o, mem_addrs_o}, 3'b000);
        reset = 1'b0; mem_rdy_i = 1'b0; m1_req_i = 1'b1;
        cyc(1);
        chk("rstb.tie", {m1_grant_o, m0_grant_o}, 2'b01);
        mem_rdy_i = 1'b1;
        cyc(1);
        chk("rstb.done", m0_rdy_o, 1'b1);
        mem_rdy_i = 1'b0; m0_req_i = 1'b0; m1_req_i = 1'b0;
        cyc(1);

        // m1 holds request through its done cycle
        m1_req_i = 1'b1;
        cyc(1);
        mem_rdy_i = 1'b1;
        cyc(1);
        chk("blk.rdy", m1_rdy_o, 1'b1);
        mem_rdy_i = 1'b0;
        cyc(1);
        chk("blk.idle", {m1_grant_o, m1_rdy_o, mem_addrs_o}, 3'b000);
        cyc(1);
        chk("blk.regrant", {m1_grant_o, mem_addrs_o}, 2'b11);
        mem_rdy_i = 1'b1;
        cyc(1);
        mem_rdy_i = 1'b0; m1_req_i = 1'b0;
        cyc(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
